// File: rtl/pu_out_quant_packer.sv
// Output stage of the PU: re-quantizes signed MAC sums to 8-bit activations,
// packs eight lanes per word and buffers packed words in a small FIFO.
module pu_out_quant_packer #(
    parameter int IN_WIDTH    = 22,
    parameter int DATA_WIDTH  = 8,
    parameter int PACK_NUM    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_WIDTH-1:0]            in_sum,
    input  logic                           in_last,
    input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
    input  logic                           sat_clr,
    output logic                           sat_flag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PACK_NUM*DATA_WIDTH-1:0] out_data,
    output logic [PACK_NUM-1:0]            out_byte_en,
    output logic                           out_last
);

    localparam int LANE_W = $clog2(PACK_NUM);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = PACK_NUM * DATA_WIDTH;

    localparam logic [SHIFT_WIDTH-1:0]   max_shift_c = SHIFT_WIDTH'(IN_WIDTH - 1);
    localparam logic signed [IN_WIDTH:0] q_max_c     = (IN_WIDTH + 1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [IN_WIDTH:0] q_min_c     = (IN_WIDTH + 1)'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic [LANE_W-1:0]        last_lane_c = LANE_W'(PACK_NUM - 1);
    localparam logic [CNT_W-1:0]         ready_lim_c = CNT_W'(FIFO_DEPTH - 1);

    // Returns {saturated, value}; the extra guard bit keeps the rounding add from overflowing.
    function automatic logic [DATA_WIDTH:0] quantize(
        input logic signed [IN_WIDTH-1:0]  sum,
        input logic [SHIFT_WIDTH-1:0]      shift
    );
        logic [SHIFT_WIDTH-1:0]   s;
        logic signed [IN_WIDTH:0] ext;
        logic signed [IN_WIDTH:0] rnd;
        logic signed [IN_WIDTH:0] shd;
        logic                     sat;
        logic [DATA_WIDTH-1:0]    q;
        s   = (shift > max_shift_c) ? max_shift_c : shift;
        ext = {sum[IN_WIDTH-1], sum};
        rnd = ext;
        if (s == {SHIFT_WIDTH{1'b0}}) begin
            shd = ext;
        end else begin
            rnd = ext + ((IN_WIDTH + 1)'(1) <<< (s - SHIFT_WIDTH'(1)));
            shd = rnd >>> s;
        end
        if (shd > q_max_c) begin
            sat = 1'b1;
            q   = q_max_c[DATA_WIDTH-1:0];
        end else if (shd < q_min_c) begin
            sat = 1'b1;
            q   = q_min_c[DATA_WIDTH-1:0];
        end else begin
            sat = 1'b0;
            q   = shd[DATA_WIDTH-1:0];
        end
        return {sat, q};
    endfunction

    logic [DATA_WIDTH:0]     quant_s;
    logic                    accept_s;
    logic                    s1_valid_r;
    logic [DATA_WIDTH-1:0]   s1_data_r;
    logic                    s1_last_r;
    logic                    sat_flag_r;
    logic [WORD_W-1:0]       pack_r;
    logic [PACK_NUM-1:0]     be_r;
    logic [LANE_W-1:0]       lane_idx_r;
    logic [WORD_W-1:0]       pack_next_s;
    logic [PACK_NUM-1:0]     be_next_s;
    logic                    word_done_s;
    logic                    push_s;
    logic                    pop_s;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [WORD_W-1:0]       mem_data [FIFO_DEPTH];
    logic [PACK_NUM-1:0]     mem_be   [FIFO_DEPTH];
    logic                    mem_last [FIFO_DEPTH];

    // One slot of headroom below full covers the element still sitting in stage 1.
    assign in_ready = (count_r < ready_lim_c);
    assign accept_s = in_valid && in_ready;
    assign quant_s  = quantize(in_sum, cfg_shift);
    assign sat_flag = sat_flag_r;

    // Stage 1: capture the quantized element on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_WIDTH{1'b0}};
            s1_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_data_r <= quant_s[DATA_WIDTH-1:0];
                s1_last_r <= in_last;
            end
        end
    end

    // Sticky saturation flag; a saturating capture beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_r <= 1'b0;
        end else if (accept_s && quant_s[DATA_WIDTH]) begin
            sat_flag_r <= 1'b1;
        end else if (sat_clr) begin
            sat_flag_r <= 1'b0;
        end
    end

    // Stage 2: merge the stage-1 element into its lane and decide whether the word closes.
    always_comb begin
        pack_next_s = pack_r;
        be_next_s   = be_r;
        word_done_s = 1'b0;
        if (s1_valid_r) begin
            pack_next_s[lane_idx_r*DATA_WIDTH +: DATA_WIDTH] = s1_data_r;
            be_next_s[lane_idx_r] = 1'b1;
            word_done_s = (lane_idx_r == last_lane_c) || s1_last_r;
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Pack register and lane pointer; a closed word leaves the register empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_r     <= {WORD_W{1'b0}};
            be_r       <= {PACK_NUM{1'b0}};
            lane_idx_r <= {LANE_W{1'b0}};
        end else if (s1_valid_r) begin
            if (word_done_s) begin
                pack_r     <= {WORD_W{1'b0}};
                be_r       <= {PACK_NUM{1'b0}};
                lane_idx_r <= {LANE_W{1'b0}};
            end else begin
                pack_r     <= pack_next_s;
                be_r       <= be_next_s;
                lane_idx_r <= lane_idx_r + LANE_W'(1);
            end
        end
    end

    assign push_s = word_done_s;
    assign pop_s  = out_valid && out_ready;

    // FIFO storage; contents need no reset because outputs are gated by the count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data[wr_ptr_r] <= pack_next_s;
            mem_be[wr_ptr_r]   <= be_next_s;
            mem_last[wr_ptr_r] <= s1_last_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-FIFO outputs, forced to zero while empty.
    always_comb begin
        out_valid   = (count_r != {CNT_W{1'b0}});
        out_data    = {WORD_W{1'b0}};
        out_byte_en = {PACK_NUM{1'b0}};
        out_last    = 1'b0;
        if (out_valid) begin
            out_data    = mem_data[rd_ptr_r];
            out_byte_en = mem_be[rd_ptr_r];
            out_last    = mem_last[rd_ptr_r];
        end else begin
            out_data    = {WORD_W{1'b0}};
            out_byte_en = {PACK_NUM{1'b0}};
            out_last    = 1'b0;
        end
    end

endmodule
